gate_tester: RTL and testbench

//   Hardware counterpart of a 2-input gate under test (GUT). On start, sweeps (a,b) through
//   00,01,10,11, samples the GUT output y, compares it against an expected truth table, and

---
 rtl/gate_tester_pkg.sv | 23 ++
 rtl/gate_tester_settle.sv | 26 ++
 rtl/gate_tester.sv | 107 ++++++++++
 tb/tb_gate_tester.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/gate_tester_pkg.sv
// Shared constants for the 2-input gate self-checker: FSM state codes,
// truth tables of common lab gates, and a vector-index helper.
package gate_tester_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE   = 2'd0;
  localparam state_t DRIVE  = 2'd1;
  localparam state_t SAMPLE = 2'd2;
  localparam state_t FINISH = 2'd3;

  // Truth tables indexed by {a,b}: bit0 = a0b0 ... bit3 = a1b1
  localparam logic [3:0] TT_NOR  = 4'b0001;
  localparam logic [3:0] TT_OR   = 4'b1110;
  localparam logic [3:0] TT_AND  = 4'b1000;
  localparam logic [3:0] TT_NAND = 4'b0111;
  localparam logic [3:0] TT_XOR  = 4'b0110;

  function automatic logic [3:0] idx_bit(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/gate_tester_settle.sv
// Load/count-down timer; expired is high while the count sits at zero.
module settle_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         expired
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst)
      cnt <= '0;
    else if (load)
      cnt <= load_val;
    else if (en && (cnt != '0))
      cnt <= cnt - 1'b1;
  end

  assign expired = (cnt == '0);

endmodule

// File: rtl/gate_tester.sv
// Sweeps a 2-input gate under test through all four input vectors, compares
// its output against EXP_TT and reports per-vector failures, error count, pass.
module gate_tester
  import gate_tester_pkg::*;
#(
  parameter logic [3:0] EXP_TT     = TT_NOR,
  parameter int         SETTLE_CYC = 1,
  parameter int         NUM_PASSES = 1,
  parameter int         CNT_W      = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             dut_a,
  output logic             dut_b,
  input  logic             dut_y,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [3:0]       fail_mask,
  output logic [CNT_W-1:0] err_count
);

  // With no settle time a vector goes straight to its sampling cycle
  localparam state_t     FIRST_STATE = (SETTLE_CYC == 0) ? SAMPLE : DRIVE;
  localparam logic [7:0] SETTLE_LOAD = (SETTLE_CYC == 0) ? 8'd0 : 8'(SETTLE_CYC - 1);
  localparam logic [7:0] LAST_PASS   = 8'(NUM_PASSES - 1);

  state_t     state;
  logic [1:0] idx;
  logic [7:0] pass_cnt;
  logic       expired;
  logic       mismatch;
  logic       last_sample;
  logic [3:0] new_mask;

  settle_timer #(.W(8)) u_settle (
    .clk      (clk),
    .rst      (rst),
    .load     (state != DRIVE),
    .load_val (SETTLE_LOAD),
    .en       (state == DRIVE),
    .expired  (expired)
  );

  assign mismatch    = (dut_y != EXP_TT[idx]);
  assign new_mask    = fail_mask | (mismatch ? idx_bit(idx) : 4'b0000);
  assign last_sample = (idx == 2'd3) && (pass_cnt == LAST_PASS);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      pass_cnt  <= '0;
      dut_a     <= 1'b0;
      dut_b     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      fail_mask <= '0;
      err_count <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state          <= FIRST_STATE;
            busy           <= 1'b1;
            pass           <= 1'b0;
            fail_mask      <= '0;
            err_count      <= '0;
            idx            <= '0;
            pass_cnt       <= '0;
            {dut_a, dut_b} <= 2'b00;
          end
        end
        DRIVE: begin
          if (expired)
            state <= SAMPLE;
        end
        SAMPLE: begin
          fail_mask <= new_mask;
          if (mismatch && (err_count != {CNT_W{1'b1}}))
            err_count <= err_count + 1'b1;
          // Index wraps 3 -> 0, so the outputs return to 00 on the way to FINISH
          idx            <= idx + 2'd1;
          {dut_a, dut_b} <= idx + 2'd1;
          if (idx == 2'd3)
            pass_cnt <= pass_cnt + 8'd1;
          if (last_sample) begin
            state <= FINISH;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (new_mask == 4'b0000);
          end else begin
            state <= FIRST_STATE;
          end
        end
        FINISH: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gate_tester.sv
// Directed bench: four tester instances with different parameters, each
// paired with a behavioural gate (NOR/OR switchable, stuck-at-0, OR, NOR).
module tb_gate_tester;
  import gate_tester_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Instance 0: default params, GUT selectable (0 = NOR, 1 = OR)
  logic start0 = 1'b0, mode0 = 1'b0;
  logic a0, b0, y0, busy0, done0, pass0;
  logic [3:0] mask0;
  logic [3:0] err0;
  assign y0 = mode0 ? (a0 | b0) : ~(a0 | b0);

  gate_tester #(.EXP_TT(TT_NOR)) u0 (
    .clk(clk), .rst(rst), .start(start0), .dut_a(a0), .dut_b(b0), .dut_y(y0),
    .busy(busy0), .done(done0), .pass(pass0), .fail_mask(mask0), .err_count(err0));

  // Instance 1: two passes, GUT output stuck at 0
  logic start1 = 1'b0;
  logic a1, b1, busy1, done1, pass1;
  logic [3:0] mask1;
  logic [3:0] err1;

  gate_tester #(.EXP_TT(TT_NOR), .NUM_PASSES(2)) u1 (
    .clk(clk), .rst(rst), .start(start1), .dut_a(a1), .dut_b(b1), .dut_y(1'b0),
    .busy(busy1), .done(done1), .pass(pass1), .fail_mask(mask1), .err_count(err1));

  // Instance 2: narrow saturating counter, OR gate checked against NOR
  logic start2 = 1'b0;
  logic a2, b2, y2, busy2, done2, pass2;
  logic [3:0] mask2;
  logic [1:0] err2;
  assign y2 = a2 | b2;

  gate_tester #(.EXP_TT(TT_NOR), .NUM_PASSES(2), .CNT_W(2)) u2 (
    .clk(clk), .rst(rst), .start(start2), .dut_a(a2), .dut_b(b2), .dut_y(y2),
    .busy(busy2), .done(done2), .pass(pass2), .fail_mask(mask2), .err_count(err2));

  // Instance 3: zero settle time, NOR gate
  logic start3 = 1'b0;
  logic a3, b3, y3, busy3, done3, pass3;
  logic [3:0] mask3;
  logic [3:0] err3;
  assign y3 = ~(a3 | b3);

  gate_tester #(.EXP_TT(TT_NOR), .SETTLE_CYC(0)) u3 (
    .clk(clk), .rst(rst), .start(start3), .dut_a(a3), .dut_b(b3), .dut_y(y3),
    .busy(busy3), .done(done3), .pass(pass3), .fail_mask(mask3), .err_count(err3));

  int sel = 0;
  logic m_a, m_b, m_busy, m_done, m_pass;
  logic [3:0] m_mask;
  logic [7:0] m_err;

  always_comb begin
    m_a = a0; m_b = b0; m_busy = busy0; m_done = done0; m_pass = pass0;
    m_mask = mask0; m_err = 8'(err0);
    case (sel)
      1: begin m_a = a1; m_b = b1; m_busy = busy1; m_done = done1; m_pass = pass1;
               m_mask = mask1; m_err = 8'(err1); end
      2: begin m_a = a2; m_b = b2; m_busy = busy2; m_done = done2; m_pass = pass2;
               m_mask = mask2; m_err = 8'(err2); end
      3: begin m_a = a3; m_b = b3; m_busy = busy3; m_done = done3; m_pass = pass3;
               m_mask = mask3; m_err = 8'(err3); end
      default: ;
    endcase
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic setStart(input int s, input logic v);
    start0 = (s == 0) ? v : 1'b0;
    start1 = (s == 1) ? v : 1'b0;
    start2 = (s == 2) ? v : 1'b0;
    start3 = (s == 3) ? v : 1'b0;
  endtask

  // Pulses start, then records {a,b} each cycle until done; lat counts cycles
  // after the start edge (-1 on timeout). A nonzero repulse_at re-raises
  // start during that cycle of the run.
  task automatic applyStimulus(input int s, input int repulse_at,
                               output int lat, output logic [15:0] seq);
    int n;
    sel = s;
    @(negedge clk); setStart(s, 1'b1);
    @(negedge clk); setStart(s, 1'b0);
    n = 1;
    seq = '0;
    while (!m_done && n < 200) begin
      seq = {seq[13:0], m_a, m_b};
      @(negedge clk);
      n++;
      setStart(s, n == repulse_at);
    end
    setStart(s, 1'b0);
    lat = m_done ? n : -1;
  endtask

  task automatic countDones(input int cycles, output int cnt);
    cnt = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (m_done) cnt++;
    end
  endtask

  int lat, cnt;
  logic [15:0] seq;

  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;
    sel = 0;
    checkOutput("rst_busy", 32'(busy0), 0);
    checkOutput("rst_done", 32'(done0), 0);
    checkOutput("rst_pass", 32'(pass0), 0);
    checkOutput("rst_mask", 32'(mask0), 0);
    checkOutput("rst_err",  32'(err0), 0);
    checkOutput("rst_ab",   32'({a0, b0}), 0);

    // NOR gate, matching table
    mode0 = 1'b0;
    applyStimulus(0, 0, lat, seq);
    checkOutput("nor_latency", 32'(lat), 9);
    checkOutput("nor_vectors", 32'(seq), 32'h05AF);
    checkOutput("nor_pass", 32'(m_pass), 1);
    checkOutput("nor_mask", 32'(m_mask), 0);
    checkOutput("nor_err",  32'(m_err), 0);
    checkOutput("nor_busy_at_done", 32'(m_busy), 0);
    checkOutput("nor_ab_at_done", 32'({m_a, m_b}), 0);
    @(negedge clk);
    checkOutput("nor_done_pulse", 32'(m_done), 0);

    // OR gate against NOR table
    mode0 = 1'b1;
    applyStimulus(0, 0, lat, seq);
    checkOutput("or_latency", 32'(lat), 9);
    checkOutput("or_pass", 32'(m_pass), 0);
    checkOutput("or_mask", 32'(m_mask), 32'hF);
    checkOutput("or_err",  32'(m_err), 4);
    repeat (3) @(negedge clk);
    checkOutput("or_mask_held", 32'(m_mask), 32'hF);
    checkOutput("or_err_held",  32'(m_err), 4);

    // Stuck-at-0 output, two passes
    applyStimulus(1, 0, lat, seq);
    checkOutput("stuck_latency", 32'(lat), 17);
    checkOutput("stuck_pass", 32'(m_pass), 0);
    checkOutput("stuck_mask", 32'(m_mask), 32'h1);
    checkOutput("stuck_err",  32'(m_err), 2);

    // Start re-pulsed while busy is ignored
    sel = 0;
    mode0 = 1'b0;
    applyStimulus(0, 3, lat, seq);
    checkOutput("repulse_latency", 32'(lat), 9);
    checkOutput("repulse_pass", 32'(m_pass), 1);
    checkOutput("repulse_mask", 32'(m_mask), 0);
    checkOutput("repulse_err",  32'(m_err), 0);
    countDones(8, cnt);
    checkOutput("repulse_extra_done", 32'(cnt), 0);

    // Reset in the middle of a failing run
    mode0 = 1'b1;
    sel = 0;
    @(negedge clk); start0 = 1'b1;
    @(negedge clk); start0 = 1'b0;
    cnt = 0;
    while (!(a0 && !b0) && cnt < 50) begin
      @(negedge clk);
      cnt++;
    end
    checkOutput("pre_rst_vector", 32'({a0, b0}), 32'h2);
    checkOutput("pre_rst_mask", 32'(mask0), 32'h3);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("mid_rst_busy", 32'(busy0), 0);
    checkOutput("mid_rst_done", 32'(done0), 0);
    checkOutput("mid_rst_ab",   32'({a0, b0}), 0);
    checkOutput("mid_rst_mask", 32'(mask0), 0);
    countDones(12, cnt);
    checkOutput("mid_rst_no_done", 32'(cnt), 0);
    mode0 = 1'b0;
    applyStimulus(0, 0, lat, seq);
    checkOutput("post_rst_latency", 32'(lat), 9);
    checkOutput("post_rst_vectors", 32'(seq), 32'h05AF);
    checkOutput("post_rst_pass", 32'(m_pass), 1);
    checkOutput("post_rst_err",  32'(m_err), 0);

    // Saturating 2-bit error counter
    applyStimulus(2, 0, lat, seq);
    checkOutput("sat_latency", 32'(lat), 17);
    checkOutput("sat_err",  32'(m_err), 3);
    checkOutput("sat_mask", 32'(m_mask), 32'hF);
    checkOutput("sat_pass", 32'(m_pass), 0);

    // Zero settle time: one cycle per vector
    applyStimulus(3, 0, lat, seq);
    checkOutput("s0_latency", 32'(lat), 5);
    checkOutput("s0_vectors", 32'(seq), 32'h001B);
    checkOutput("s0_pass", 32'(m_pass), 1);

    // Start held high: one idle cycle between back-to-back runs
    sel = 0;
    @(negedge clk); start0 = 1'b1;
    cnt = 0;
    while (!done0 && cnt < 50) begin
      @(negedge clk);
      cnt++;
    end
    checkOutput("b2b_done_seen", 32'(done0), 1);
    @(negedge clk);
    checkOutput("b2b_idle_gap", 32'(busy0), 0);
    @(negedge clk);
    checkOutput("b2b_restart", 32'(busy0), 1);
    start0 = 1'b0;
    cnt = 0;
    while (!done0 && cnt < 50) begin
      @(negedge clk);
      cnt++;
    end
    checkOutput("b2b_second_done", 32'(done0), 1);
    checkOutput("b2b_second_pass", 32'(pass0), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
